// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller for the 5-stage CPU
//
// Detects load-use hazards, taken branches and jumps, and scoreboards the
// multi-cycle mul/div unit. Sequences the IF/ID and ID/EX stage registers
// and the PC.
//
// Optional feature macro: HAZARD_PERF_CNT_EN (enables stall/flush counters).
//
// Ports:
//   Clk, Reset            clock (rising edge), synchronous active-high reset
//   ID_Rs, ID_Rt          source registers of the ID instruction
//   ID_UsesRs, ID_UsesRt  ID instruction actually reads Rs / Rt
//   ID_Jump               jump resolved in ID
//   ID_MulDiv             ID instruction is mult/multu/div/divu
//   ID_ReadHiLo           ID instruction is mfhi/mflo
//   EX_MemRead            EX instruction is a load
//   EX_WriteReg           destination register of the EX instruction
//   EX_BranchTaken        branch resolved taken in EX
//   PC_Write              PC update enable
//   Bubble_from_loaduse   hold IF/ID
//   Bubble_from_ca        clear IF/ID
//   IDEX_Flush            load a NOP into ID/EX
//   MulDiv_Start          one-cycle start pulse to the mul/div unit
//   MulDiv_Busy           mul/div result not yet valid
//   StallCnt, FlushCnt    performance counters
module hazard_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             ID_MulDiv,
  input  logic             ID_ReadHiLo,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             EX_BranchTaken,
  output logic             PC_Write,
  output logic             Bubble_from_loaduse,
  output logic             Bubble_from_ca,
  output logic             IDEX_Flush,
  output logic             MulDiv_Start,
  output logic             MulDiv_Busy,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES);

  logic [5:0] md_cnt;
  logic       md_busy;
  logic       lu;
  logic       hl;

  // Hazard terms. A load to $0 never creates a dependency.
  always_comb begin
    md_busy = (md_cnt != 6'd0);
    lu = EX_MemRead && (EX_WriteReg != 5'd0) &&
         ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
          (ID_UsesRt && (ID_Rt == EX_WriteReg)));
    hl = md_busy && (ID_ReadHiLo || ID_MulDiv);
  end

  // Priority decision: taken branch > stall > jump > normal flow.
  always_comb begin
    PC_Write            = 1'b0;
    Bubble_from_loaduse = 1'b0;
    Bubble_from_ca      = 1'b0;
    IDEX_Flush          = 1'b0;
    MulDiv_Start        = 1'b0;
    MulDiv_Busy         = 1'b0;
    if (!Reset) begin
      MulDiv_Busy = md_busy;
      if (EX_BranchTaken) begin
        Bubble_from_ca = 1'b1;
        IDEX_Flush     = 1'b1;
        PC_Write       = 1'b1;
      end else if (lu || hl) begin
        // ID is held and re-evaluated next cycle; a NOP goes down to EX.
        Bubble_from_loaduse = 1'b1;
        IDEX_Flush          = 1'b1;
      end else begin
        PC_Write       = 1'b1;
        Bubble_from_ca = ID_Jump;
        MulDiv_Start   = ID_MulDiv;
      end
    end
  end

  // Mul/div scoreboard. A later branch flush does not cancel an op in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      md_cnt <= 6'd0;
    end else if (MulDiv_Start) begin
      md_cnt <= MD_LOAD;
    end else if (md_cnt != 6'd0) begin
      md_cnt <= md_cnt - 6'd1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (Bubble_from_loaduse) stall_cnt <= stall_cnt + 1'b1;
      if (Bubble_from_ca)      flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int MD    = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_wr;
  logic          id_urs, id_urt, id_jump, id_md, id_hilo;
  logic          ex_mr, ex_bt;
  logic          pc_write, b_lu, b_ca, idex_flush, md_start, md_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: absolute cycle index and the first cycle at
  // which the mul/div unit is free again.
  int            cyc = 0;
  int            md_free = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;
  int            stalls_seen;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_CYCLES(MD), .CNT_W(CW)) dut (
    .Clk                 (clk),
    .Reset               (rst),
    .ID_Rs               (id_rs),
    .ID_Rt               (id_rt),
    .ID_UsesRs           (id_urs),
    .ID_UsesRt           (id_urt),
    .ID_Jump             (id_jump),
    .ID_MulDiv           (id_md),
    .ID_ReadHiLo         (id_hilo),
    .EX_MemRead          (ex_mr),
    .EX_WriteReg         (ex_wr),
    .EX_BranchTaken      (ex_bt),
    .PC_Write            (pc_write),
    .Bubble_from_loaduse (b_lu),
    .Bubble_from_ca      (b_ca),
    .IDEX_Flush          (idex_flush),
    .MulDiv_Start        (md_start),
    .MulDiv_Busy         (md_busy),
    .StallCnt            (stall_cnt),
    .FlushCnt            (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clr();
    rst = 1'b0; id_rs = '0; id_rt = '0; ex_wr = '0;
    id_urs = 1'b0; id_urt = 1'b0; id_jump = 1'b0; id_md = 1'b0;
    id_hilo = 1'b0; ex_mr = 1'b0; ex_bt = 1'b0;
  endtask

  // One clock cycle: inputs were set by the caller just after the previous
  // edge; outputs are checked mid-cycle, then the model advances at the edge.
  task automatic step();
    bit busy, dep, stall, e_pc, e_lu, e_ca, e_fl, e_st, e_busy;
    @(negedge clk);
    #1;
    busy  = (cyc < md_free);
    dep   = ex_mr && ex_wr != 0 &&
            ((id_urs && id_rs == ex_wr) || (id_urt && id_rt == ex_wr));
    stall = dep || (busy && (id_hilo || id_md));
    {e_pc, e_lu, e_ca, e_fl, e_st, e_busy} = '0;
    if (!rst) begin
      e_busy = busy;
      if (ex_bt) begin
        e_pc = 1; e_ca = 1; e_fl = 1;
      end else if (stall) begin
        e_lu = 1; e_fl = 1;
      end else begin
        e_pc = 1; e_ca = id_jump; e_st = id_md;
      end
    end
    chk("pc_write", 32'(pc_write), 32'(e_pc));
    chk("bubble_loaduse", 32'(b_lu), 32'(e_lu));
    chk("bubble_ca", 32'(b_ca), 32'(e_ca));
    chk("idex_flush", 32'(idex_flush), 32'(e_fl));
    chk("muldiv_start", 32'(md_start), 32'(e_st));
    chk("muldiv_busy", 32'(md_busy), 32'(e_busy));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`else
    chk("stall_cnt", 32'(stall_cnt), 32'd0);
    chk("flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    if (b_lu === 1'b1) stalls_seen++;
    if (rst) begin
      md_free = cyc + 1;
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (e_st) md_free = cyc + MD + 1;
      if (e_lu) m_stall = m_stall + 1'b1;
      if (e_ca) m_flush = m_flush + 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    clr();
    // Initial reset, observed through the model from the first edge on.
    rst = 1'b1;
    @(posedge clk); #1; cyc++;
    step();

    // Load-use: lw $8 in EX, add reading $8 in ID -> one stall cycle.
    clr(); ex_mr = 1; ex_wr = 5'd8; id_urs = 1; id_rs = 5'd8; id_urt = 1; id_rt = 5'd3;
    stalls_seen = 0;
    step();
    clr(); id_urs = 1; id_rs = 5'd8;
    step();
    chk("loaduse_len", 32'(stalls_seen), 32'd1);

    // Load to $0 never stalls; Rt-side dependency does.
    clr(); ex_mr = 1; ex_wr = 5'd0; id_urs = 1; id_rs = 5'd0;
    step();
    clr(); ex_mr = 1; ex_wr = 5'd9; id_urt = 1; id_rt = 5'd9; id_rs = 5'd9;
    step();

    // Branch together with load-use and a mult: branch wins, no start.
    clr(); ex_bt = 1; ex_mr = 1; ex_wr = 5'd8; id_urs = 1; id_rs = 5'd8; id_md = 1;
    step();

    // Mult issued, then mflo stalls MD cycles, then proceeds.
    clr(); id_md = 1;
    step();
    clr(); id_hilo = 1;
    stalls_seen = 0;
    for (int i = 0; i < MD + 1; i++) step();
    chk("mflo_stall_len", 32'(stalls_seen), 32'(MD));

    // Back-to-back mul/div: second waits for the scoreboard to drain.
    clr(); id_md = 1;
    step();
    stalls_seen = 0;
    for (int i = 0; i < MD + 1; i++) step();
    chk("md_b2b_stall_len", 32'(stalls_seen), 32'(MD));
    clr();
    for (int i = 0; i < MD; i++) step();

    // Lone jump, then load-use together with jump (stall wins).
    clr(); id_jump = 1;
    step();
    ex_mr = 1; ex_wr = 5'd5; id_urs = 1; id_rs = 5'd5;
    step();
    clr(); id_jump = 1;
    step();

    // Reset while the scoreboard holds 2: mflo right after is not stalled.
    clr(); id_md = 1;
    step();
    clr();
    step(); step();
    rst = 1;
    step();
    clr(); id_hilo = 1;
    step();
    chk("post_reset_busy", 32'(md_busy), 32'd0);

    // Randomized traffic with small register numbers to provoke hits.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 39) == 0);
      id_rs   = 5'($urandom_range(0, 3));
      id_rt   = 5'($urandom_range(0, 3));
      ex_wr   = 5'($urandom_range(0, 3));
      id_urs  = 1'($urandom_range(0, 1));
      id_urt  = 1'($urandom_range(0, 1));
      ex_mr   = ($urandom_range(0, 2) == 0);
      ex_bt   = ($urandom_range(0, 7) == 0);
      id_jump = ($urandom_range(0, 5) == 0);
      id_md   = ($urandom_range(0, 5) == 0);
      id_hilo = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage CPU. It sequences the IF/ID and ID/EX stage registers and the PC. It detects load-use hazards and taken branches/jumps, and scoreboards the multi-cycle multiply/divide unit. It drives the `Bubble_from_ca` and `Bubble_from_loaduse` inputs of the IF/ID register, the ID/EX flush, the PC write enable and the mul/div start pulse.

## Interface
- `MD_CYCLES`, 32, mul/div latency in cycles, legal 2..63
- `CNT_W`, 32, width of the performance counters
- `Clk` in 1: clock, rising edge
- `Reset` in 1: synchronous, active-high
- `ID_Rs`, `ID_Rt` in 5: source register numbers of the instruction in ID
- `ID_UsesRs`, `ID_UsesRt` in 1: the ID instruction actually reads Rs / Rt
- `ID_Jump` in 1: jump (j/jal/jr) resolved in ID
- `ID_MulDiv` in 1: the ID instruction is mult/multu/div/divu
- `ID_ReadHiLo` in 1: the ID instruction is mfhi/mflo
- `EX_MemRead` in 1: the EX instruction is a load
- `EX_WriteReg` in 5: destination register of the EX instruction
- `EX_BranchTaken` in 1: branch resolved taken in EX
- `PC_Write` out 1: PC update enable
- `Bubble_from_loaduse` out 1: hold IF/ID
- `Bubble_from_ca` out 1: clear IF/ID
- `IDEX_Flush` out 1: load a NOP into ID/EX
- `MulDiv_Start` out 1: one-cycle start pulse to the mul/div unit
- `MulDiv_Busy` out 1: mul/div result not yet valid
- `StallCnt`, `FlushCnt` out `CNT_W`: performance counters

## Operation
- Internal registered counter `MdCnt` (6 bits). `MulDiv_Busy` = (`MdCnt` != 0).
- `LU` = `EX_MemRead` & (`EX_WriteReg` != 0) & ((`ID_UsesRs` & `ID_Rs` == `EX_WriteReg`) | (`ID_UsesRt` & `ID_Rt` == `EX_WriteReg`)).
- `HL` = `MulDiv_Busy` & (`ID_ReadHiLo` | `ID_MulDiv`).
- Decisions are evaluated by priority, highest first:
  1. `EX_BranchTaken`: `Bubble_from_ca`=1, `IDEX_Flush`=1, `PC_Write`=1, `Bubble_from_loaduse`=0, `MulDiv_Start`=0. Stall and jump are ignored.
  2. `LU` | `HL` (stall): `Bubble_from_loaduse`=1, `PC_Write`=0, `IDEX_Flush`=1, `Bubble_from_ca`=0, `MulDiv_Start`=0. ID is re-evaluated next cycle.
  3. `ID_Jump`: `Bubble_from_ca`=1, `IDEX_Flush`=0, `PC_Write`=1.
  4. Otherwise: `PC_Write`=1, all bubble and flush outputs 0.
- `MulDiv_Start` = `ID_MulDiv` & !`EX_BranchTaken` & !`LU` & !`HL`.
- `MdCnt` update:
  - On a start, load `MD_CYCLES`.
  - Otherwise, if nonzero, decrement by 1.
  - A branch flush does not cancel an op already started.
- Outputs while `Reset`=1: `PC_Write`=0, all bubble, flush and start outputs 0, `MulDiv_Busy`=0.
- At the reset edge, `MdCnt` and the performance counters clear to 0.

## Timing
- Hazard outputs are combinational from the current-cycle inputs and `MdCnt`, with zero latency. They must settle before the `Clk` edge that the stage registers sample.
- A load-use stall lasts exactly 1 cycle: the next cycle the load has left EX.
- A mul/div issued at edge N gives `MulDiv_Busy`=1 for cycles N+1..N+`MD_CYCLES`. An mfhi/mflo in ID proceeds in the first cycle with `MdCnt`=0.
- Back-to-back mul/div: the second stalls until `MdCnt`=0, then starts in that same cycle.
- Simultaneous `LU` and `ID_Jump`: the stall wins and the jump is re-evaluated next cycle.
- Simultaneous `EX_BranchTaken` with anything else: the flush wins and the ID instruction is discarded.
- `Reset` mid-mul/div: `MdCnt` is 0 on the next cycle and no stall follows.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `StallCnt` increments each cycle that `Bubble_from_loaduse`=1.
  - `FlushCnt` increments each cycle that `Bubble_from_ca`=1.
  - Both wrap modulo 2^`CNT_W` and clear on `Reset`.
- Not defined: both ports are driven constant 0 and no counter registers exist.

## Test plan
- Load-use: EX lw `$8`, ID add using `$8` as Rs → exactly 1 cycle of `Bubble_from_loaduse`=1, `PC_Write`=0, `IDEX_Flush`=1; the following cycle is all 0 with `PC_Write`=1.
- Load to `$0`: EX lw with `EX_WriteReg`=0, ID reads `$0` → no stall.
- Branch plus load-use together: `EX_BranchTaken`=1 with `LU` true → `Bubble_from_ca`=1, `IDEX_Flush`=1, `Bubble_from_loaduse`=0, `PC_Write`=1.
- Mul/div scoreboard with `MD_CYCLES`=4: mult issued, then mflo in ID → `MulDiv_Start` pulses for 1 cycle, then 4 stall cycles, then mflo proceeds. A second mult issued during busy starts only when `MdCnt`=0.
- Jump: `ID_Jump`=1 alone → `Bubble_from_ca`=1, `IDEX_Flush`=0. With `HAZARD_PERF_CNT_EN`, `FlushCnt` increments by 1.
- Reset at `MdCnt`=2 → next cycle `MulDiv_Busy`=0, mflo not stalled, and `StallCnt`/`FlushCnt`=0.
